// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM states, branch opcodes and the
// branch-taken rule, also used by the control decoder.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  function automatic logic branch_taken(input logic [5:0] op, input logic alu_zero);
    return ((op == OP_BEQ) && alu_zero) || ((op == OP_BNE) && !alu_zero);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Next-PC selection: jump target, taken branch target or fall-through.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  logic signed [31:0] br_off;
  logic        [31:0] jump_tgt;

  assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jump_tgt = {pc_plus4[31:28], instr[25:0], 2'b00};

  // jump is tested first so a don't-care branch from jal cannot leak through
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_tgt;
    end else if (branch && branch_taken(instr[31:26], alu_zero)) begin
      next_pc = pc_plus4 + $unsigned(br_off);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: fetches the word at PC, holds it for decode/execute,
// then advances PC to the jump/branch/sequential successor.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        branch,
  input  logic        alu_zero
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_calc u_next_pc_calc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .jump     (jump),
    .branch   (branch),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // ack is only honoured in FETCH and exec_done only in ISSUE
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == FETCH);
    imem_addr   = pc_q;
    instr       = instr_q;
    op          = instr_q[31:26];
    instr_valid = valid_q;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address, equal to the PC.
REQ-006 SHALL have port imem_ack  input  1  read-data-valid strobe from instruction memory.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, sampled when imem_ack=1.
REQ-008 SHALL have port instr  output  32  held instruction word for decode and execute.
REQ-009 SHALL have port op  output  6  instr[31:26], fed to the control decoder.
REQ-010 SHALL have port instr_valid  output  1  instr/op/pc_plus4 are valid.
REQ-011 SHALL have port pc_plus4  output  32  PC+4 of the held instruction, used for the jal link write.
REQ-012 SHALL have port exec_done  input  1  one-cycle pulse: execute done; jump/branch/alu_zero valid this cycle.
REQ-013 SHALL have port jump, branch  input  1 each  control-decoder outputs for the held instruction.
REQ-014 SHALL have port alu_zero  input  1  ALU zero flag of the held instruction.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, ISSUE.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-017 FETCH SHALL drive imem_req=1 and imem_addr=PC, and SHALL stay in FETCH until imem_ack=1.
REQ-018 On imem_ack in FETCH: latch imem_rdata into instr, set instr_valid=1 and go to ISSUE next cycle (one-cycle latency from ack to valid).
REQ-019 ISSUE SHALL hold instr, op and pc_plus4 stable with imem_req=0 until exec_done=1.
REQ-020 On exec_done in ISSUE: load PC with next_pc, clear instr_valid and go to FETCH in the same edge.
REQ-021 next_pc, highest priority first:
 - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}
 - branch=1 and taken: pc_plus4 + (sign-extended instr[15:0] << 2)
 - otherwise: pc_plus4
REQ-022 Taken SHALL be decided from op: 6'b000100 (beq) when alu_zero=1; 6'b000101 (bne) when alu_zero=0; any other op with branch=1 is not taken.
REQ-023 jump=1 SHALL override an unknown or asserted branch (jal drives branch as don't-care).
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-025 PC[1:0] SHALL always be 2'b00.
REQ-026 exec_done outside ISSUE SHALL be ignored.
REQ-027 imem_ack outside FETCH SHALL be ignored.
REQ-028 imem_ack and exec_done in the same cycle SHALL only act according to the current state.

Reset
REQ-029 reset_n=0 at a clock edge SHALL set PC=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0 and pc_plus4=RESET_PC+4.
REQ-030 Reset asserted mid-FETCH or mid-ISSUE SHALL abandon the operation. An ack arriving after reset for the abandoned fetch SHALL be ignored, because the FSM is then in IDLE.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the opcode constants OP_BEQ=6'b000100 and OP_BNE=6'b000101. The control decoder SHALL use the same constants.
REQ-032 next_pc selection SHALL be one combinational sub-module, next_pc_calc, with inputs pc_plus4, instr, jump, branch and alu_zero.

Verification
REQ-033 Reset release, ack after 3 wait cycles with rdata=32'h0000_0020 -> imem_addr=0, instr_valid rises one cycle after ack, op=0, pc_plus4=4.
REQ-034 PC=0x100, beq (imm=16'hFFFF), alu_zero=1, exec_done -> next imem_addr=0x100. Same with alu_zero=0 -> 0x104.
REQ-035 bne imm=3 at PC=0x40: alu_zero=0 -> 0x50; alu_zero=1 -> 0x44.
REQ-036 jal target 26'h0000010 at PC=0x1000_0000, jump=1, branch=x -> imem_addr=0x1000_0040, pc_plus4 during ISSUE was 0x1000_0004.
REQ-037 reset_n=0 during FETCH with a late ack the next cycle -> instr_valid stays 0, instr=0; fetch restarts at RESET_PC after one IDLE cycle.
REQ-038 PC=32'hFFFF_FFFC, non-branch, exec_done -> imem_addr wraps to 0. A spurious exec_done during FETCH -> no PC change.
